slot_alloc: RTL and testbench



---
 rtl/slot_alloc.sv | 130 +++++++++++++
 tb/tb_slot_alloc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc.sv
// Slot allocator: offers the lowest free slot index on valid/ready, frees slots on a binary release strobe.
// Latency: all outputs registered; a transfer or release shows in busy/cnt one cycle later, re-offer after 1 cycle.
// Backpressure: offer (alc_bin) held stable while alc_vld && !alc_rdy; releases are always accepted.
module slot_alloc #(
  parameter  int WIDTH          = 32,
  parameter  int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 alc_vld,
  input  logic                 alc_rdy,
  output logic [WIDTH_LOG-1:0] alc_bin,
  input  logic                 rel_vld,
  input  logic [WIDTH_LOG-1:0] rel_bin,
  output logic [WIDTH-1:0]     busy,
  output logic [WIDTH_LOG:0]   cnt,
  output logic                 full,
  output logic                 empty,
  output logic                 err
);

  logic                 xfer;
  logic                 reload;
  logic                 rel_in_range;
  logic                 rel_legal;
  logic                 found;
  logic [WIDTH-1:0]     xfer_oh;
  logic [WIDTH-1:0]     rel_oh;
  logic [WIDTH-1:0]     busy_next;
  logic [WIDTH_LOG-1:0] first_free;
  logic [WIDTH_LOG:0]   cnt_next;

  // Release decoder: several equivalent styles, chosen at elaboration.
  // Every style yields an all-zero mask for an out-of-range index.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $fatal(1, "slot_alloc: WIDTH must be at least 2");
    end

    case (IMPLEMENTATION)
      0: begin : g_table
        logic [WIDTH-1:0] dec_tbl [2**WIDTH_LOG];
        for (genvar j = 0; j < 2**WIDTH_LOG; j++) begin : g_ent
          if (j < WIDTH) begin : g_in
            assign dec_tbl[j] = WIDTH'(1) << j;
          end else begin : g_out
            assign dec_tbl[j] = '0;
          end
        end
        assign rel_oh = dec_tbl[rel_bin];
      end
      1: begin : g_loop
        // Compare the index against every slot number.
        always_comb begin
          rel_oh = '0;
          for (int i = 0; i < WIDTH; i++) begin
            rel_oh[i] = (rel_bin == WIDTH_LOG'(i));
          end
        end
      end
      2: begin : g_power
        localparam logic [WIDTH:0] TWO = (WIDTH+1)'(2);
        logic [WIDTH:0] pow;
        assign pow    = TWO ** rel_bin;
        assign rel_oh = pow[WIDTH-1:0];
      end
      3: begin : g_shift
        assign rel_oh = WIDTH'(1) << rel_bin;
      end
      default: begin : g_bad_impl
        $fatal(1, "slot_alloc: IMPLEMENTATION must be 0..3");
      end
    endcase
  endgenerate

  assign xfer         = alc_vld & alc_rdy;
  assign reload       = ~alc_vld | xfer;
  assign xfer_oh      = xfer ? (WIDTH'(1) << alc_bin) : '0;
  assign rel_in_range = ({1'b0, rel_bin} < (WIDTH_LOG+1)'(WIDTH));
  // The offered slot is still free in busy, so releasing it (or the slot being
  // transferred this cycle) is naturally rejected by the busy-bit test.
  assign rel_legal    = rel_vld & rel_in_range & (|(busy & rel_oh));
  assign busy_next    = (busy | xfer_oh) & ~(rel_legal ? rel_oh : '0);

  // Priority search for the lowest-index free slot in the next bitmap.
  always_comb begin
    found      = 1'b0;
    first_free = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!busy_next[i]) begin
        found      = 1'b1;
        first_free = WIDTH_LOG'(i);
      end
    end
  end

  // Population count of the next bitmap, registered alongside busy.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next = cnt_next + (WIDTH_LOG+1)'(busy_next[i]);
    end
  end

  // Bitmap, status and offer registers; the offer only moves on reload so it
  // stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy    <= '0;
      cnt     <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      err     <= 1'b0;
      alc_vld <= 1'b0;
      alc_bin <= '0;
    end else begin
      busy  <= busy_next;
      cnt   <= cnt_next;
      full  <= &busy_next;
      empty <= ~|busy_next;
      err   <= rel_vld & ~rel_legal;
      if (reload) begin
        alc_vld <= found;
        alc_bin <= found ? first_free : '0;
      end
    end
  end

endmodule

// File: tb/tb_slot_alloc.sv
// Directed bench for slot_alloc: four instances covering widths 8/4/6/8 and decoder styles 0..3.
// Each table row drives one instance for one cycle and checks its registered outputs after the edge.
// A closing hand-written burst exercises back-to-back allocation until the pool is exhausted.
module tb_slot_alloc;

  logic clk;
  logic rst_n;
  logic [3:0] rdy;
  logic [3:0] rv;
  logic [2:0] rb [4];

  // Zero-extended views of every instance's outputs.
  logic       o_vld   [4];
  logic [2:0] o_bin   [4];
  logic [7:0] o_busy  [4];
  logic [3:0] o_cnt   [4];
  logic       o_full  [4];
  logic       o_empty [4];
  logic       o_err   [4];

  logic [2:0] bin0, bin2, bin3;
  logic [1:0] bin1;
  logic [7:0] busy0, busy3;
  logic [3:0] busy1;
  logic [5:0] busy2;
  logic [3:0] cnt0, cnt2, cnt3;
  logic [2:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  slot_alloc #(.WIDTH(8), .IMPLEMENTATION(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .alc_vld(o_vld[0]), .alc_rdy(rdy[0]), .alc_bin(bin0),
    .rel_vld(rv[0]), .rel_bin(rb[0]), .busy(busy0), .cnt(cnt0),
    .full(o_full[0]), .empty(o_empty[0]), .err(o_err[0]));

  slot_alloc #(.WIDTH(4), .IMPLEMENTATION(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .alc_vld(o_vld[1]), .alc_rdy(rdy[1]), .alc_bin(bin1),
    .rel_vld(rv[1]), .rel_bin(rb[1][1:0]), .busy(busy1), .cnt(cnt1),
    .full(o_full[1]), .empty(o_empty[1]), .err(o_err[1]));

  slot_alloc #(.WIDTH(6), .IMPLEMENTATION(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .alc_vld(o_vld[2]), .alc_rdy(rdy[2]), .alc_bin(bin2),
    .rel_vld(rv[2]), .rel_bin(rb[2]), .busy(busy2), .cnt(cnt2),
    .full(o_full[2]), .empty(o_empty[2]), .err(o_err[2]));

  slot_alloc #(.WIDTH(8), .IMPLEMENTATION(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .alc_vld(o_vld[3]), .alc_rdy(rdy[3]), .alc_bin(bin3),
    .rel_vld(rv[3]), .rel_bin(rb[3]), .busy(busy3), .cnt(cnt3),
    .full(o_full[3]), .empty(o_empty[3]), .err(o_err[3]));

  assign o_bin[0]  = bin0;
  assign o_bin[1]  = {1'b0, bin1};
  assign o_bin[2]  = bin2;
  assign o_bin[3]  = bin3;
  assign o_busy[0] = busy0;
  assign o_busy[1] = {4'b0, busy1};
  assign o_busy[2] = {2'b0, busy2};
  assign o_busy[3] = busy3;
  assign o_cnt[0]  = cnt0;
  assign o_cnt[1]  = {1'b0, cnt1};
  assign o_cnt[2]  = cnt2;
  assign o_cnt[3]  = cnt3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         d;
    logic       rst;
    logic       rdy;
    logic       rv;
    logic [2:0] rb;
    logic       vld;
    logic [2:0] bin;
    logic [7:0] busy;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       err;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(int d, logic rst, logic rdy_i, logic rv_i, logic [2:0] rb_i,
                              logic vld, logic [2:0] bin, logic [7:0] busy, logic [3:0] cnt,
                              logic full, logic empty, logic err);
    row_t r;
    r.d = d; r.rst = rst; r.rdy = rdy_i; r.rv = rv_i; r.rb = rb_i;
    r.vld = vld; r.bin = bin; r.busy = busy; r.cnt = cnt;
    r.full = full; r.empty = empty; r.err = err;
    return r;
  endfunction

  function automatic void chk(string name, int tag, int d, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d dut%0d: got %0h expected %0h", name, tag, d, act, exp);
    end
  endfunction

  task automatic check_all(int tag, row_t r);
    chk("alc_vld", tag, r.d, 32'(o_vld[r.d]),   32'(r.vld));
    chk("alc_bin", tag, r.d, 32'(o_bin[r.d]),   32'(r.bin));
    chk("busy",    tag, r.d, 32'(o_busy[r.d]),  32'(r.busy));
    chk("cnt",     tag, r.d, 32'(o_cnt[r.d]),   32'(r.cnt));
    chk("full",    tag, r.d, 32'(o_full[r.d]),  32'(r.full));
    chk("empty",   tag, r.d, 32'(o_empty[r.d]), 32'(r.empty));
    chk("err",     tag, r.d, 32'(o_err[r.d]),   32'(r.err));
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = '0;
    rv    = '0;
    for (int k = 0; k < 4; k++) rb[k] = '0;

    // d rst rdy rv rb | vld bin busy cnt full empty err
    // Reset held 3 cycles, then startup offer of slot 0.
    rows.push_back(mk(0,0,0,0,0, 0,0,8'h00,0,0,1,0));
    rows.push_back(mk(0,0,0,0,0, 0,0,8'h00,0,0,1,0));
    rows.push_back(mk(3,0,0,0,0, 0,0,8'h00,0,0,1,0));
    rows.push_back(mk(0,1,0,0,0, 1,0,8'h00,0,0,1,0));
    // WIDTH=8: allocate 0..2, stall on offer 3 while slot 1 is released.
    rows.push_back(mk(0,1,1,0,0, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(0,1,1,0,0, 1,2,8'h03,2,0,0,0));
    rows.push_back(mk(0,1,1,0,0, 1,3,8'h07,3,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 1,3,8'h07,3,0,0,0));
    rows.push_back(mk(0,1,0,1,1, 1,3,8'h05,2,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 1,3,8'h05,2,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 1,3,8'h05,2,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 1,3,8'h05,2,0,0,0));
    rows.push_back(mk(0,1,1,0,0, 1,1,8'h0D,3,0,0,0));
    // Rearrange to slots 0,1 busy with offer 2, then transfer 2 + release 0.
    rows.push_back(mk(0,1,0,1,2, 1,1,8'h09,2,0,0,0));
    rows.push_back(mk(0,1,0,1,3, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(0,1,1,0,0, 1,2,8'h03,2,0,0,0));
    rows.push_back(mk(0,1,1,1,0, 1,0,8'h06,2,0,0,0));
    // Release of the slot being transferred: transfer completes, err pulses once.
    rows.push_back(mk(0,1,1,1,0, 1,3,8'h07,3,0,0,1));
    rows.push_back(mk(0,1,0,0,0, 1,3,8'h07,3,0,0,0));
    // WIDTH=4: burst to full, release/re-offer, simultaneous events.
    rows.push_back(mk(1,1,1,0,0, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(1,1,1,0,0, 1,2,8'h03,2,0,0,0));
    rows.push_back(mk(1,1,1,0,0, 1,3,8'h07,3,0,0,0));
    rows.push_back(mk(1,1,1,0,0, 0,0,8'h0F,4,1,0,0));
    rows.push_back(mk(1,1,0,0,0, 0,0,8'h0F,4,1,0,0));
    rows.push_back(mk(1,1,0,1,2, 1,2,8'h0B,3,0,0,0));
    rows.push_back(mk(1,1,0,1,3, 1,2,8'h03,2,0,0,0));
    rows.push_back(mk(1,1,1,1,0, 1,0,8'h06,2,0,0,0));
    // WIDTH=6: illegal releases (free, offered, out of range), then simultaneous events.
    rows.push_back(mk(2,1,1,0,0, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(2,1,0,1,5, 1,1,8'h01,1,0,0,1));
    rows.push_back(mk(2,1,0,0,0, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(2,1,0,1,1, 1,1,8'h01,1,0,0,1));
    rows.push_back(mk(2,1,0,0,0, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(2,1,0,1,7, 1,1,8'h01,1,0,0,1));
    rows.push_back(mk(2,1,0,0,0, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(2,1,1,0,0, 1,2,8'h03,2,0,0,0));
    rows.push_back(mk(2,1,1,1,0, 1,0,8'h06,2,0,0,0));
    // WIDTH=8 shift decoder: simultaneous events.
    rows.push_back(mk(3,1,1,0,0, 1,1,8'h01,1,0,0,0));
    rows.push_back(mk(3,1,1,0,0, 1,2,8'h03,2,0,0,0));
    rows.push_back(mk(3,1,1,1,0, 1,0,8'h06,2,0,0,0));
    // Mid-operation reset discards allocations and the pending offer; inputs ignored.
    rows.push_back(mk(0,0,1,1,1, 0,0,8'h00,0,0,1,0));
    rows.push_back(mk(0,1,0,0,0, 1,0,8'h00,0,0,1,0));

    for (int r = 0; r < rows.size(); r++) begin
      rst_n = rows[r].rst;
      rdy   = '0;
      rv    = '0;
      rdy[rows[r].d] = rows[r].rdy;
      rv[rows[r].d]  = rows[r].rv;
      rb[rows[r].d]  = rows[r].rb;
      @(posedge clk);
      #1;
      check_all(r, rows[r]);
    end

    // Back-to-back allocation on WIDTH=8 with ready held high: 0..7, no bubbles.
    rdy = '0;
    rv  = '0;
    rdy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("burst_vld", 100 + i, 0, 32'(o_vld[0]), 32'd1);
      chk("burst_bin", 100 + i, 0, 32'(o_bin[0]), 32'(i));
      @(posedge clk);
      #1;
    end
    begin
      int waited = 0;
      while (o_full[0] !== 1'b1 && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
      end
      chk("burst_full_wait", 200, 0, 32'(waited), 32'd0);
    end
    chk("burst_full",  201, 0, 32'(o_full[0]), 32'd1);
    chk("burst_vld",   202, 0, 32'(o_vld[0]),  32'd0);
    chk("burst_cnt",   203, 0, 32'(o_cnt[0]),  32'd8);
    chk("burst_busy",  204, 0, 32'(o_busy[0]), 32'hFF);
    rdy = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
